// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX read-side sequencer.
// Holds the FSM state type, frame constants and the parity helper.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 139;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic parity_bit(
    input logic [UART_DATA_BITS-1:0] data,
    input logic                      odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled.
// bit_tick marks the last cycle of each bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign bit_tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART TX sequencer: pops bytes from the FIFO read port and
// serializes them as start, 8 data bits LSB first, parity, stop.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        rd_clk,
  input  logic        rst_rd_n,
  input  logic        tx_en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] bytes_sent
);

  localparam int SW =
    (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  tx_state_t                 state;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [SW-1:0]             stop_idx;
  logic                      bit_tick;
  logic                      timer_en;
  logic                      start_ok;

  assign timer_en = (state == START) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);
  assign start_ok = tx_en && !fifo_empty;
  assign busy     = (state != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (rd_clk),
    .rst_n   (rst_rd_n),
    .clr     (!timer_en),
    .en      (timer_en),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge rd_clk or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      bytes_sent <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      stop_idx   <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state      <= REQ;
            fifo_rd_en <= 1'b1;
          end
        end
        REQ: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg   <= fifo_dout;
          tx      <= 1'b0;
          bit_idx <= '0;
          state   <= START;
        end
        START: begin
          if (bit_tick) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
              stop_idx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit(shreg, ODD);
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            tx       <= 1'b1;
            stop_idx <= '0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop_idx == STOP_LAST) begin
              frame_done <= 1'b1;
              bytes_sent <= bytes_sent + 16'd1;
              // chain straight into the next pop when data is waiting
              if (start_ok) begin
                state      <= REQ;
                fifo_rd_en <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench: three DUT configurations, a FIFO model,
// and a line decoder that checks every frame seen on tx.
module tb_uart_tx_fifo_ctrl;

  localparam int CL = 4;
  localparam int NI = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic        fifo_empty [NI];
  logic [7:0]  fifo_dout  [NI];
  logic        rd_en      [NI];
  logic        tx         [NI];
  logic        busy       [NI];
  logic        done       [NI];
  logic [15:0] bsent      [NI];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  fifo_q [NI][$];
  logic [7:0]  exp_q  [NI][$];
  int          gap_q  [$];
  int          rd_cnt    [NI];
  logic        prev_rd   [NI];
  bit          act       [NI];
  int          n         [NI];
  logic [63:0] smp       [NI];
  logic [15:0] sent      [NI];
  int          last_done [NI];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_fifo_ctrl #(
      .CLKS_PER_BIT(CL),
      .PARITY_EN   (g > 0 ? 1 : 0),
      .PARITY_ODD  (g == 2 ? 1 : 0),
      .STOP_BITS   (g > 0 ? 2 : 1)
    ) u_dut (
      .rd_clk    (clk),
      .rst_rd_n  (rst_n),
      .tx_en     (tx_en),
      .fifo_empty(fifo_empty[g]),
      .fifo_dout (fifo_dout[g]),
      .fifo_rd_en(rd_en[g]),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .frame_done(done[g]),
      .bytes_sent(bsent[g])
    );
  end

  function automatic int pe(input int i);
    return (i > 0) ? 1 : 0;
  endfunction

  function automatic int po(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int sb(input int i);
    return (i > 0) ? 2 : 1;
  endfunction

  function automatic int nbits(input int i);
    return 1 + 8 + pe(i) + sb(i);
  endfunction

  task automatic check_eq(
    input string       name,
    input logic [63:0] got,
    input logic [63:0] req
  );
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // FIFO model with one cycle read latency
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        rd_cnt[i]  <= 0;
        prev_rd[i] <= 1'b0;
      end else begin
        prev_rd[i] <= rd_en[i];
        if (rd_en[i]) begin
          rd_cnt[i] <= rd_cnt[i] + 1;
          check_eq("rd_en_one_cycle", 64'(prev_rd[i]), 64'd0);
          check_eq("rd_en_nonempty",
                   64'(fifo_q[i].size() > 0), 64'd1);
          if (fifo_q[i].size() > 0)
            fifo_dout[i] <= fifo_q[i].pop_front();
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++)
      fifo_empty[i] <= (fifo_q[i].size() == 0);
  end

  task automatic finish_frame(input int i);
    logic [7:0] got;
    logic [7:0] want;
    logic       v;
    logic       shape;
    int         nb;
    nb    = nbits(i);
    got   = '0;
    shape = 1'b1;
    check_eq("frame_done_at_end", 64'(done[i]), 64'd1);
    for (int b = 0; b < nb; b++) begin
      v = smp[i][b*CL];
      for (int k = 1; k < CL; k++)
        if (smp[i][b*CL+k] !== v) shape = 1'b0;
      if (b == 0 && v !== 1'b0) shape = 1'b0;
      if (b >= 1 && b <= 8) got[b-1] = v;
      if (b >= nb - sb(i) && v !== 1'b1) shape = 1'b0;
    end
    check_eq("frame_shape", 64'(shape), 64'd1);
    check_eq("frame_expected", 64'(exp_q[i].size() > 0), 64'd1);
    if (exp_q[i].size() > 0) begin
      want = exp_q[i].pop_front();
      check_eq("data_byte", 64'(got), 64'(want));
      if (pe(i) == 1)
        check_eq("parity_bit", 64'(smp[i][9*CL]),
                 64'(($countones(want) % 2) ^ po(i)));
    end
    check_eq("bytes_sent", 64'(bsent[i]), 64'(sent[i] + 16'd1));
  endtask

  // line decoder: one sample per negedge, frame checked after stop
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        act[i]       <= 1'b0;
        n[i]         <= 0;
        sent[i]      <= '0;
        last_done[i] <= -1000;
      end else if (act[i] && n[i] < nbits(i) * CL) begin
        smp[i][n[i]] <= tx[i];
        n[i]         <= n[i] + 1;
        check_eq("frame_done_in_frame", 64'(done[i]), 64'd0);
      end else if (act[i]) begin
        finish_frame(i);
        act[i]       <= 1'b0;
        last_done[i] <= cyc;
        sent[i]      <= sent[i] + 16'd1;
      end else if (tx[i] === 1'b0) begin
        act[i]    <= 1'b1;
        n[i]      <= 1;
        smp[i]    <= '0;
        if (i == 0 && cyc - last_done[0] < 100)
          gap_q.push_back(cyc - last_done[0]);
      end else begin
        check_eq("frame_done_idle", 64'(done[i]), 64'd0);
      end
    end
  end

  task automatic push(input int i, input logic [7:0] b);
    fifo_q[i].push_back(b);
    exp_q[i].push_back(b);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int  t;
    bit  idle;
    t = 0;
    forever begin
      idle = 1'b1;
      for (int i = 0; i < NI; i++)
        if (fifo_q[i].size() != 0 || exp_q[i].size() != 0 ||
            busy[i] || act[i]) idle = 1'b0;
      if (idle || t >= budget) break;
      tick(1);
      t++;
    end
    check_eq("drain_in_time", 64'(t < budget), 64'd1);
  endtask

  task automatic wait_tx_low(input int i, input int budget);
    int t;
    t = 0;
    while (tx[i] !== 1'b0 && t < budget) begin
      tick(1);
      t++;
    end
    check_eq("tx_start_in_time", 64'(t < budget), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    rst_n = 1'b0;
    tx_en = 1'b0;
    tick(5);

    // idle with empty FIFO
    rst_n = 1'b1;
    tx_en = 1'b1;
    tick(20);
    check_eq("t1_tx", 64'(tx[0]), 64'd1);
    check_eq("t1_busy", 64'(busy[0]), 64'd0);
    check_eq("t1_bytes", 64'(bsent[0]), 64'd0);
    check_eq("t1_rd_cnt", 64'(rd_cnt[0]), 64'd0);
    tick(100);

    // single byte, start latency
    push(0, 8'h55);
    @(posedge clk); #1;
    check_eq("t2_rd_en_e1", 64'(rd_en[0]), 64'd1);
    check_eq("t2_tx_e1", 64'(tx[0]), 64'd1);
    @(posedge clk); #1;
    check_eq("t2_rd_en_e2", 64'(rd_en[0]), 64'd0);
    check_eq("t2_tx_e2", 64'(tx[0]), 64'd1);
    @(posedge clk); #1;
    check_eq("t2_tx_e3", 64'(tx[0]), 64'd0);
    wait_drain(200);
    check_eq("t2_bytes", 64'(bsent[0]), 64'd1);
    check_eq("t2_rd_cnt", 64'(rd_cnt[0]), 64'd1);

    // back-to-back burst
    tx_en = 1'b0;
    gap_q.delete();
    base = rd_cnt[0];
    for (int b = 0; b < 4; b++) push(0, 8'(8'h10 + b));
    tick(110);
    check_eq("t3_hold_no_rd", 64'(rd_cnt[0]), 64'(base));
    tx_en = 1'b1;
    t = 0;
    while (!busy[0] && t < 20) begin tick(1); t++; end
    t = 0;
    while (!(done[0] && exp_q[0].size() == 1) && t < 400) begin
      check_eq("t3_busy", 64'(busy[0]), 64'd1);
      tick(1);
      t++;
    end
    wait_drain(200);
    check_eq("t3_rd_cnt", 64'(rd_cnt[0]), 64'(base + 4));
    check_eq("t3_bytes", 64'(bsent[0]), 64'd5);
    check_eq("t3_gap_count", 64'(gap_q.size()), 64'd3);
    foreach (gap_q[k]) check_eq("t3_gap", 64'(gap_q[k]), 64'd2);

    // parity and two stop bits
    push(1, 8'h07);
    push(2, 8'h07);
    push(1, 8'($urandom));
    push(2, 8'($urandom));
    wait_drain(400);
    check_eq("t4_bytes_even", 64'(bsent[1]), 64'd2);
    check_eq("t4_bytes_odd", 64'(bsent[2]), 64'd2);

    // tx_en dropped mid-frame
    base = rd_cnt[0];
    push(0, 8'hAB);
    push(0, 8'h11);
    wait_tx_low(0, 20);
    tick(10);
    tx_en = 1'b0;
    t = 0;
    while (exp_q[0].size() != 1 && t < 100) begin tick(1); t++; end
    tick(30);
    check_eq("t5_rd_cnt_hold", 64'(rd_cnt[0]), 64'(base + 1));
    check_eq("t5_busy_hold", 64'(busy[0]), 64'd0);
    check_eq("t5_pending", 64'(fifo_q[0].size()), 64'd1);
    tx_en = 1'b1;
    wait_drain(200);
    check_eq("t5_rd_cnt_resume", 64'(rd_cnt[0]), 64'(base + 2));

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 1)
        push(int'($urandom_range(0, NI - 1)), 8'($urandom));
      tx_en = ($urandom_range(0, 3) != 0);
      tick(int'($urandom_range(0, 25)));
    end
    tx_en = 1'b1;
    wait_drain(8000);
    for (int i = 0; i < NI; i++)
      check_eq("rand_bytes_sent", 64'(bsent[i]), 64'(sent[i]));

    // asynchronous reset mid-frame
    push(0, 8'($urandom));
    push(0, 8'($urandom));
    wait_tx_low(0, 20);
    tick(12);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_tx", 64'(tx[0]), 64'd1);
    check_eq("t6_busy", 64'(busy[0]), 64'd0);
    check_eq("t6_rd_en", 64'(rd_en[0]), 64'd0);
    check_eq("t6_bytes", 64'(bsent[0]), 64'd0);
    for (int i = 0; i < NI; i++) begin
      fifo_q[i].delete();
      exp_q[i].delete();
    end
    tick(3);
    rst_n = 1'b1;
    tick(30);
    check_eq("t6_idle_busy", 64'(busy[0]), 64'd0);
    check_eq("t6_idle_tx", 64'(tx[0]), 64'd1);
    check_eq("t6_idle_rd", 64'(rd_cnt[0]), 64'd0);
    check_eq("t6_idle_bytes", 64'(bsent[0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
